sys_bus_arbiter: RTL

Two-master arbiter and sequencer for the system bus. Accepts single-beat read/write requests from two requesters (m0, m1), grants the bus round-robin, and drives the bus's ALE/command handshake (`ale_en`, `bus_read_en`/`bus_write_en`, address, write data). It waits for `bus_ready`, returns read data and a one-cycle `done` to the owner, then rearbitrates. It sits between the masters (CPU core, DMA) and the system bus controller.

---
 rtl/sys_bus_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sys_bus_arbiter.sv
// Two-master round-robin arbiter that sequences single-beat bus transfers through ALE/CMD/WAIT/DONE.
// Optional WAIT timeout abort is enabled by defining BUS_ARB_TIMEOUT_EN.
module sys_bus_arbiter #(
    parameter int MEM_WIDTH = 8,
    parameter int MEM_DEPTH = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_m0_req,
    input  logic                 i_m0_we,
    input  logic [MEM_DEPTH-1:0] i_m0_addr,
    input  logic [MEM_WIDTH-1:0] i_m0_wdata,
    output logic                 o_m0_gnt,
    output logic                 o_m0_done,
    output logic                 o_m0_err,
    output logic [MEM_WIDTH-1:0] o_m0_rdata,
    input  logic                 i_m1_req,
    input  logic                 i_m1_we,
    input  logic [MEM_DEPTH-1:0] i_m1_addr,
    input  logic [MEM_WIDTH-1:0] i_m1_wdata,
    output logic                 o_m1_gnt,
    output logic                 o_m1_done,
    output logic                 o_m1_err,
    output logic [MEM_WIDTH-1:0] o_m1_rdata,
    output logic                 o_ale_en,
    output logic                 o_bus_read_en,
    output logic                 o_bus_write_en,
    output logic [MEM_DEPTH-1:0] o_addr_input,
    output logic [MEM_WIDTH-1:0] o_data_write,
    input  logic [MEM_WIDTH-1:0] i_data_read,
    input  logic                 i_bus_ready,
    output logic                 o_busy
);

    // state  | meaning
    // IDLE   | arbitrate, latch winner's operands
    // ALE    | address latch strobe
    // CMD    | read or write strobe
    // WAIT   | wait for bus_ready (or timeout)
    // DONE   | completion pulse to owner, update last
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ALE  = 3'd1,
        S_CMD  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_last;
    logic                   r_owner;
    logic                   r_we;
    logic [MEM_DEPTH-1:0]   r_addr;
    logic [MEM_WIDTH-1:0]   r_wdata;
    logic [MEM_WIDTH-1:0]   r_rdata0;
    logic [MEM_WIDTH-1:0]   r_rdata1;
    logic                   w_grant;
    logic                   w_gid;
    logic                   w_timeout;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [4:0]             r_cnt;
    logic                   r_err;
    assign w_timeout = (r_cnt == 5'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_gid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant = i_m0_req | i_m1_req;
                // On a tie the master not served last wins; last resets to 1 so m0 wins first.
                if (i_m0_req && i_m1_req) w_gid = ~r_last;
                else                      w_gid = i_m1_req;
                if (w_grant) w_next = S_ALE;
            end
            S_ALE:  w_next = S_CMD;
            S_CMD:  w_next = S_WAIT;
            S_WAIT: if (i_bus_ready || w_timeout) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_gid;
                r_we    <= w_gid ? i_m1_we    : i_m0_we;
                r_addr  <= w_gid ? i_m1_addr  : i_m0_addr;
                r_wdata <= w_gid ? i_m1_wdata : i_m0_wdata;
            end
            if (r_state == S_WAIT && i_bus_ready && !r_we) begin
                if (r_owner) r_rdata1 <= i_data_read;
                else         r_rdata0 <= i_data_read;
            end
            if (r_state == S_DONE) r_last <= r_owner;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_CMD)       r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 5'd1;
            // bus_ready in the same cycle as the timeout still counts as success.
            if (r_state == S_CMD)       r_err <= 1'b0;
            else if (r_state == S_WAIT) r_err <= w_timeout && !i_bus_ready;
        end
    end
    assign o_m0_err = (r_state == S_DONE) && !r_owner && r_err;
    assign o_m1_err = (r_state == S_DONE) &&  r_owner && r_err;
`else
    assign o_m0_err = 1'b0;
    assign o_m1_err = 1'b0;
`endif

    assign o_busy         = (r_state != S_IDLE);
    assign o_ale_en       = (r_state == S_ALE);
    assign o_bus_write_en = (r_state == S_CMD) &&  r_we;
    assign o_bus_read_en  = (r_state == S_CMD) && !r_we;
    assign o_addr_input   = o_busy ? r_addr  : '0;
    assign o_data_write   = o_busy ? r_wdata : '0;
    assign o_m0_gnt       = o_busy && !r_owner;
    assign o_m1_gnt       = o_busy &&  r_owner;
    assign o_m0_done      = (r_state == S_DONE) && !r_owner;
    assign o_m1_done      = (r_state == S_DONE) &&  r_owner;
    assign o_m0_rdata     = r_rdata0;
    assign o_m1_rdata     = r_rdata1;

endmodule
